// File: rtl/tone_gen_pkg.sv
// Shared types and constants for the tone generator: sample width, waveform
// select encodings, amplitude constants and the waveform shaping function.
package tone_gen_pkg;

    localparam int SAMPLE_W = 24;

    typedef enum logic [1:0] {
        WAVE_SQUARE  = 2'b00,
        WAVE_SAW     = 2'b01,
        WAVE_TRI     = 2'b10,
        WAVE_SILENCE = 2'b11
    } wave_e;

    localparam logic [SAMPLE_W-1:0] AMP_POS  = 24'h7FFFFF;
    localparam logic [SAMPLE_W-1:0] AMP_NEG  = 24'h800000;
    localparam logic [SAMPLE_W-1:0] MSB_FLIP = 24'h800000;

    // Maps an unsigned phase to a signed full-scale sample; MSB_FLIP turns
    // an offset-binary ramp into two's complement.
    function automatic logic [SAMPLE_W-1:0] shape_wave(input wave_e sel,
                                                       input logic [SAMPLE_W-1:0] p);
        logic [SAMPLE_W-1:0] t;
        logic [SAMPLE_W-1:0] w;
        t = {p[SAMPLE_W-2:0], 1'b0};
        w = '0;
        case (sel)
            WAVE_SQUARE: w = p[SAMPLE_W-1] ? AMP_NEG : AMP_POS;
            WAVE_SAW:    w = p ^ MSB_FLIP;
            WAVE_TRI:    w = (p[SAMPLE_W-1] ? ~t : t) ^ MSB_FLIP;
            default:     w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/sample_tick_div.sv
// Sample-rate divider: counts 0..DIV-1 and emits a one-cycle tick on the
// last count of each period.
module sample_tick_div #(
    parameter int DIV = 64
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign tick_o = (count_q == CNT_LAST);

    always_comb begin
        count_d = count_q + 1'b1;
        if (tick_o) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/tone_gen.sv
// Tone generator: phase accumulator feeding a capture/shape/scale pipeline
// with a valid/ready output register. Optional fade-out when TONE_GEN_FADE_EN.
module tone_gen
    import tone_gen_pkg::*;
#(
    parameter int SAMPLE_DIV   = 64,
    parameter int FADE_SAMPLES = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [23:0]         tone_step,
    input  logic [1:0]          wave_sel,
    input  logic [3:0]          volume,
    output logic [SAMPLE_W-1:0] sample_l,
    output logic [SAMPLE_W-1:0] sample_r,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                overrun,
    input  logic                overrun_clr
);

    logic tick;

    sample_tick_div #(.DIV(SAMPLE_DIV)) u_div (
        .clk    (clk),
        .rst    (rst),
        .tick_o (tick)
    );

    logic [SAMPLE_W-1:0] phase_q,    phase_d;
    logic                s1_valid_q, s1_valid_d;
    logic [SAMPLE_W-1:0] s1_phase_q, s1_phase_d;
    logic                s1_mute_q,  s1_mute_d;
    logic [3:0]          s1_atten_q, s1_atten_d;
    logic                s2_valid_q, s2_valid_d;
    logic [SAMPLE_W-1:0] s2_wave_q,  s2_wave_d;
    logic [3:0]          s2_atten_q, s2_atten_d;
    logic [SAMPLE_W-1:0] out_q,      out_d;
    logic                valid_q,    valid_d;
    logic                overrun_q,  overrun_d;

    logic                cap_mute;
    logic [3:0]          cap_atten;
    logic                advance;
    logic [SAMPLE_W-1:0] scaled;

`ifdef TONE_GEN_FADE_EN
    localparam int FCNT_W = (FADE_SAMPLES > 1) ? $clog2(FADE_SAMPLES) : 1;
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FADE_SAMPLES - 1);

    logic [3:0]        atten_q, atten_d;
    logic              mute_q,  mute_d;
    logic [FCNT_W-1:0] fcnt_q,  fcnt_d;

    // Fade state only moves on ticks; the phase keeps running until fully muted.
    always_comb begin
        atten_d   = atten_q;
        mute_d    = mute_q;
        fcnt_d    = fcnt_q;
        cap_atten = enable ? volume : atten_q;
        cap_mute  = !enable && mute_q;
        advance   = enable || !mute_q;
        if (tick) begin
            if (enable) begin
                atten_d = volume;
                mute_d  = 1'b0;
                fcnt_d  = '0;
            end else if (!mute_q) begin
                if (fcnt_q == FCNT_LAST) begin
                    fcnt_d = '0;
                    if (atten_q == 4'hF) begin
                        mute_d = 1'b1;
                    end else begin
                        atten_d = atten_q + 4'd1;
                    end
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            atten_q <= '0;
            mute_q  <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            atten_q <= atten_d;
            mute_q  <= mute_d;
            fcnt_q  <= fcnt_d;
        end
    end
`else
    assign cap_atten = volume;
    assign cap_mute  = !enable;
    assign advance   = enable;
`endif

    assign scaled = $unsigned($signed(s2_wave_q) >>> s2_atten_q);

    always_comb begin
        phase_d    = phase_q;
        s1_valid_d = tick;
        s1_phase_d = s1_phase_q;
        s1_mute_d  = s1_mute_q;
        s1_atten_d = s1_atten_q;
        s2_valid_d = s1_valid_q;
        s2_wave_d  = s2_wave_q;
        s2_atten_d = s2_atten_q;
        out_d      = out_q;
        valid_d    = valid_q;
        overrun_d  = overrun_q;

        if (tick) begin
            s1_phase_d = phase_q;
            s1_mute_d  = cap_mute;
            s1_atten_d = cap_atten;
            if (advance) begin
                phase_d = phase_q + tone_step;
            end
        end

        if (s1_valid_q) begin
            s2_wave_d  = s1_mute_q ? '0 : shape_wave(wave_e'(wave_sel), s1_phase_q);
            s2_atten_d = s1_atten_q;
        end

        // A load with the old sample still pending and not taken is an overrun;
        // it takes priority over a same-cycle clear.
        if (overrun_clr) begin
            overrun_d = 1'b0;
        end
        if (s2_valid_q) begin
            out_d   = scaled;
            valid_d = 1'b1;
            if (valid_q && !sample_ready) begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && sample_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q    <= '0;
            s1_valid_q <= 1'b0;
            s1_phase_q <= '0;
            s1_mute_q  <= 1'b0;
            s1_atten_q <= '0;
            s2_valid_q <= 1'b0;
            s2_wave_q  <= '0;
            s2_atten_q <= '0;
            out_q      <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            s1_valid_q <= s1_valid_d;
            s1_phase_q <= s1_phase_d;
            s1_mute_q  <= s1_mute_d;
            s1_atten_q <= s1_atten_d;
            s2_valid_q <= s2_valid_d;
            s2_wave_q  <= s2_wave_d;
            s2_atten_q <= s2_atten_d;
            out_q      <= out_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign sample_l     = out_q;
    assign sample_r     = out_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_tone_gen.sv
// Directed bench for tone_gen: table of waveform vectors plus hand-written
// latency, handshake/overrun, reset-flush and enable sequences.
module tb_tone_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [23:0] tone_step;
    logic [1:0]  wave_sel;
    logic [3:0]  volume;
    logic [23:0] sample_l;
    logic [23:0] sample_r;
    logic        sample_valid;
    logic        sample_ready;
    logic        overrun;
    logic        overrun_clr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tone_gen dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .tone_step    (tone_step),
        .wave_sel     (wave_sel),
        .volume       (volume),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr)
    );

    typedef struct packed {
        logic [1:0]       wave;
        logic [23:0]      step;
        logic [3:0]       vol;
        logic [3:0][23:0] exp;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic set_vec(input int i, input logic [1:0] w, input logic [23:0] s,
                           input logic [3:0] v, input logic [23:0] e0, input logic [23:0] e1,
                           input logic [23:0] e2, input logic [23:0] e3);
        vecs[i].wave   = w;
        vecs[i].step   = s;
        vecs[i].vol    = v;
        vecs[i].exp[0] = e0;
        vecs[i].exp[1] = e1;
        vecs[i].exp[2] = e2;
        vecs[i].exp[3] = e3;
    endtask

    task automatic do_reset(input logic [1:0] w, input logic [23:0] s, input logic [3:0] v);
        @(negedge clk);
        rst          = 1'b1;
        wave_sel     = w;
        tone_step    = s;
        volume       = v;
        enable       = 1'b1;
        sample_ready = 1'b1;
        overrun_clr  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Returns the number of rising edges until sample_valid is seen.
    task automatic wait_valid(output int cyc, output logic [23:0] v);
        cyc = -1;
        v   = '0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if (sample_valid) begin
                cyc = i;
                v   = sample_l;
                break;
            end
        end
        if (cyc < 0) begin
            checks++;
            failures++;
            $display("FAIL wait_valid: got timeout expected sample_valid within 200 cycles");
        end
    endtask

    initial begin
        int          cyc;
        logic [23:0] v;

        rst = 1'b1; enable = 1'b1; tone_step = '0; wave_sel = 2'b00;
        volume = '0; sample_ready = 1'b1; overrun_clr = 1'b0;

        set_vec(0, 2'b00, 24'h000000, 4'd0,  24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF);
        set_vec(1, 2'b01, 24'h100000, 4'd0,  24'h800000, 24'h900000, 24'hA00000, 24'hB00000);
        set_vec(2, 2'b10, 24'h400000, 4'd0,  24'h800000, 24'h000000, 24'h7FFFFF, 24'hFFFFFF);
        set_vec(3, 2'b00, 24'h800000, 4'd4,  24'h07FFFF, 24'hF80000, 24'h07FFFF, 24'hF80000);
        set_vec(4, 2'b01, 24'h000000, 4'd15, 24'hFFFF00, 24'hFFFF00, 24'hFFFF00, 24'hFFFF00);
        set_vec(5, 2'b11, 24'h123456, 4'd0,  24'h000000, 24'h000000, 24'h000000, 24'h000000);
        set_vec(6, 2'b01, 24'h700000, 4'd1,  24'hC00000, 24'hF80000, 24'h300000, 24'hE80000);

        // First-sample latency and sample period
        do_reset(2'b00, 24'h0, 4'd0);
        wait_valid(cyc, v);
        chk("first_latency", cyc, 66);
        chk("first_value", v, 24'h7FFFFF);
        wait_valid(cyc, v);
        chk("sample_period", cyc, 64);

        for (int i = 0; i < 7; i++) begin
            do_reset(vecs[i].wave, vecs[i].step, vecs[i].vol);
            for (int k = 0; k < 4; k++) begin
                wait_valid(cyc, v);
                chk($sformatf("vec%0d_s%0d_l", i, k), v, vecs[i].exp[k]);
                chk($sformatf("vec%0d_s%0d_r", i, k), sample_r, vecs[i].exp[k]);
            end
        end

        // Saw wraps to the start after 16 samples
        do_reset(2'b01, 24'h100000, 4'd0);
        for (int k = 0; k < 17; k++) begin
            logic [23:0] e;
            e = (24'(k % 16) << 20) ^ 24'h800000;
            wait_valid(cyc, v);
            if (k >= 14) chk($sformatf("saw_wrap_s%0d", k), v, e);
        end

        // Overrun, clear, clear-vs-set priority, transfer
        do_reset(2'b01, 24'h100000, 4'd0);
        sample_ready = 1'b0;
        wait_valid(cyc, v);
        chk("ovr_first_value", v, 24'h800000);
        chk("ovr_not_yet", overrun, 0);
        repeat (64) @(posedge clk);
        #1;
        chk("ovr_set", overrun, 1);
        chk("ovr_newest", sample_l, 24'h900000);
        chk("ovr_valid_held", sample_valid, 1);
        @(negedge clk) overrun_clr = 1'b1;
        @(negedge clk) overrun_clr = 1'b0;
        chk("ovr_cleared", overrun, 0);
        chk("ovr_stable", sample_l, 24'h900000);
        overrun_clr = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (sample_l != 24'h900000) break;
        end
        chk("ovr_set_beats_clr", overrun, 1);
        chk("ovr_third_value", sample_l, 24'hA00000);
        @(negedge clk);
        overrun_clr  = 1'b0;
        sample_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("xfer_valid_drop", sample_valid, 0);
        chk("ovr_sticky", overrun, 1);

        // Reset state
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_valid", sample_valid, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_sample", sample_l, 0);

        // Reset with samples in flight must flush them
        do_reset(2'b01, 24'h100000, 4'd0);
        repeat (65) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        chk("flush_valid_low", sample_valid, 0);
        wait_valid(cyc, v);
        chk("flush_latency", cyc, 66);
        chk("flush_value", v, 24'h800000);

        // Enable low silences one sample and holds the phase
        do_reset(2'b01, 24'h100000, 4'd0);
        wait_valid(cyc, v);
        chk("en_first", v, 24'h800000);
        @(negedge clk) enable = 1'b0;
        wait_valid(cyc, v);
        chk("en_off_zero", v, 24'h000000);
        @(negedge clk) enable = 1'b1;
        wait_valid(cyc, v);
        chk("en_phase_held", v, 24'h900000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
